// File: rtl/cnt_share_sched.sv
// cnt_share_sched: round-robin scheduler sharing one CNT_W-bit accumulator
// between NUM_REQ requesters. Each update is done as two sequenced half-width
// adds (low half, then carry into high half) through a single adder.
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   clr         synchronous clear of counter, ovf and pointer (highest priority)
//   req         per-requester level request, held until granted
//   inc         packed increments, slice i belongs to req[i]
//   gnt         one-hot grant pulse, high during the ADD_LO cycle
//   counter     accumulator value (coherent only when busy=0)
//   out         low 32 bits of counter
//   busy        update in flight
//   ovf         sticky carry-out of the top counter bit
module cnt_share_sched #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned INC_W   = 32,
  parameter int unsigned CNT_W   = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*INC_W-1:0] inc,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [CNT_W-1:0]         counter,
  output logic [31:0]              out,
  output logic                     busy,
  output logic                     ovf
);

  localparam int unsigned PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned HALF_W = CNT_W / 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ADD_LO = 2'd1,
    ADD_HI = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [PTR_W-1:0]     win_q, win_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [INC_W-1:0]     inc_lat_q, inc_lat_d;
  logic                 carry_q, carry_d;
  logic [CNT_W-1:0]     counter_q, counter_d;
  logic                 ovf_q, ovf_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic                 busy_q, busy_d;

  logic                 arb_found;
  logic [PTR_W-1:0]     arb_idx;
  int unsigned          cand;

  logic [HALF_W-1:0]    add_a, add_b;
  logic [HALF_W:0]      add_sum;

  // Round-robin search starting at ptr_q
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = 0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      cand = (32'(ptr_q) + 32'(k)) % NUM_REQ;
      if (!arb_found && req[PTR_W'(cand)]) begin
        arb_found = 1'b1;
        arb_idx   = PTR_W'(cand);
      end
    end
  end

  // Single shared half-width adder: low half + increment, or high half + carry
  always_comb begin
    add_a   = (state_q == ADD_LO) ? counter_q[HALF_W-1:0] : counter_q[CNT_W-1:HALF_W];
    add_b   = (state_q == ADD_LO) ? HALF_W'(inc_lat_q)    : HALF_W'(carry_q);
    add_sum = {1'b0, add_a} + {1'b0, add_b};
  end

  // Next-state and next-output logic
  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    ptr_d     = ptr_q;
    inc_lat_d = inc_lat_q;
    carry_d   = carry_q;
    counter_d = counter_q;
    ovf_d     = ovf_q;
    gnt_d     = '0;
    busy_d    = 1'b0;

    if (clr) begin
      state_d   = IDLE;
      counter_d = '0;
      ovf_d     = 1'b0;
      ptr_d     = '0;
      carry_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (arb_found) begin
            win_d     = arb_idx;
            inc_lat_d = inc[32'(arb_idx)*INC_W +: INC_W];
            state_d   = ADD_LO;
          end
        end
        ADD_LO: begin
          counter_d[HALF_W-1:0] = add_sum[HALF_W-1:0];
          carry_d               = add_sum[HALF_W];
          state_d               = ADD_HI;
        end
        ADD_HI: begin
          counter_d[CNT_W-1:HALF_W] = add_sum[HALF_W-1:0];
          if (add_sum[HALF_W]) ovf_d = 1'b1;
          ptr_d   = (32'(win_q) == NUM_REQ - 1) ? '0 : win_q + PTR_W'(1);
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    // Grant register holds the decode of the upcoming ADD_LO cycle
    if (state_d == ADD_LO) gnt_d[win_d] = 1'b1;
    busy_d = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      win_q     <= '0;
      ptr_q     <= '0;
      inc_lat_q <= '0;
      carry_q   <= 1'b0;
      counter_q <= '0;
      ovf_q     <= 1'b0;
      gnt_q     <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      ptr_q     <= ptr_d;
      inc_lat_q <= inc_lat_d;
      carry_q   <= carry_d;
      counter_q <= counter_d;
      ovf_q     <= ovf_d;
      gnt_q     <= gnt_d;
      busy_q    <= busy_d;
    end
  end

  assign gnt     = gnt_q;
  assign counter = counter_q;
  assign out     = 32'(counter_q);
  assign busy    = busy_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_cnt_share_sched.sv
// Directed testbench for cnt_share_sched. A default-size instance covers
// grant timing, carry, round robin, clr and async reset; a 16-bit instance
// makes the 64-bit-style overflow reachable in a few hundred updates.
module tb_cnt_share_sched;

  logic          clk;
  logic          rst_n;

  logic          clr;
  logic [3:0]    req;
  logic [127:0]  inc;
  logic [3:0]    gnt;
  logic [63:0]   counter;
  logic [31:0]   out;
  logic          busy;
  logic          ovf;

  logic          s_clr;
  logic [1:0]    s_req;
  logic [15:0]   s_inc;
  logic [1:0]    s_gnt;
  logic [15:0]   s_counter;
  logic [31:0]   s_out;
  logic          s_busy;
  logic          s_ovf;

  int n_checks = 0;
  int n_errors = 0;

  cnt_share_sched #(.NUM_REQ(4), .INC_W(32), .CNT_W(64)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .req(req), .inc(inc),
    .gnt(gnt), .counter(counter), .out(out), .busy(busy), .ovf(ovf)
  );

  cnt_share_sched #(.NUM_REQ(2), .INC_W(8), .CNT_W(16)) dut_s (
    .clk(clk), .rst_n(rst_n), .clr(s_clr), .req(s_req), .inc(s_inc),
    .gnt(s_gnt), .counter(s_counter), .out(s_out), .busy(s_busy), .ovf(s_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full update on the main instance with a grant check
  task automatic do_update(input int idx, input logic [31:0] val);
    req = 4'(1 << idx);
    inc[idx*32 +: 32] = val;
    tick();
    check("upd_gnt", 64'(gnt), 64'(1 << idx));
    req = '0;
    tick();
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    clr = 1'b0; req = '0; inc = '0;
    s_clr = 1'b0; s_req = '0; s_inc = '0;
    tick();
    tick();
    check("rst_counter", counter, 64'd0);
    check("rst_gnt", 64'(gnt), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    rst_n = 1'b1;

    // Single request
    req = 4'b0001; inc[31:0] = 32'd5;
    tick();
    check("single_gnt", 64'(gnt), 64'h1);
    check("single_busy_lo", 64'(busy), 64'd1);
    req = '0;
    tick();
    check("single_gnt_hi", 64'(gnt), 64'd0);
    check("single_out_hi", 64'(out), 64'd5);
    tick();
    check("single_counter", counter, 64'd5);
    check("single_busy_done", 64'(busy), 64'd0);
    check("single_out", 64'(out), 64'd5);

    // Carry propagation into the high half
    do_update(0, 32'hFFFF_FFFA);
    check("preload", counter, 64'h0000_0000_FFFF_FFFF);
    req = 4'b0001; inc[31:0] = 32'd1;
    tick();
    check("carry_gnt", 64'(gnt), 64'h1);
    req = '0;
    tick();
    check("carry_out_lo", 64'(out), 64'd0);
    check("carry_hi_pending", 64'(counter[63:32]), 64'd0);
    tick();
    check("carry_done", counter, 64'h1_0000_0000);

    // Round robin with all requesters
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_counter", counter, 64'd0);
    req = 4'hF;
    inc = {4{32'd1}};
    for (int i = 0; i < 12; i++) begin
      tick();
      check($sformatf("rr_gnt%0d", i), 64'(gnt), (i % 3 == 0) ? 64'(1 << (i / 3)) : 64'd0);
    end
    req = '0;
    check("rr_counter", counter, 64'd4);
    check("rr_busy", 64'(busy), 64'd0);

    // clr during ADD_LO: grant pulses, add discarded, pointer back to 0
    do_update(1, 32'd2);
    check("pre_clr_counter", counter, 64'd6);
    req = 4'b0100; inc[64 +: 32] = 32'd7;
    tick();
    check("clr_lo_gnt", 64'(gnt), 64'h4);
    clr = 1'b1; req = '0;
    tick();
    clr = 1'b0;
    check("clr_lo_counter", counter, 64'd0);
    check("clr_lo_busy", 64'(busy), 64'd0);
    check("clr_lo_gnt_off", 64'(gnt), 64'd0);
    check("clr_lo_ovf", 64'(ovf), 64'd0);
    req = 4'hF;
    inc = {4{32'd1}};
    tick();
    check("clr_ptr_gnt", 64'(gnt), 64'h1);
    req = '0;
    tick();
    tick();
    check("clr_after_counter", counter, 64'd1);

    // clr in IDLE with a pending request: no grant
    req = 4'b0001; clr = 1'b1;
    tick();
    check("clr_idle_gnt", 64'(gnt), 64'd0);
    check("clr_idle_busy", 64'(busy), 64'd0);
    clr = 1'b0; req = '0;
    tick();

    // Async reset during ADD_HI
    req = 4'b0001; inc[31:0] = 32'd9;
    tick();
    req = '0;
    tick();
    check("ar_busy_hi", 64'(busy), 64'd1);
    check("ar_out_hi", 64'(out), 64'd9);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_counter", counter, 64'd0);
    check("ar_gnt", 64'(gnt), 64'd0);
    check("ar_busy", 64'(busy), 64'd0);
    tick();
    rst_n = 1'b1;

    // Overflow on the 16-bit instance: 257 * 255 = 16'hFFFF
    s_req = 2'b01; s_inc = 16'h00FF;
    repeat (771) tick();
    s_req = '0;
    check("s_full", 64'(s_counter), 64'hFFFF);
    check("s_full_out", 64'(s_out), 64'h0000_FFFF);
    check("s_full_ovf", 64'(s_ovf), 64'd0);
    check("s_full_busy", 64'(s_busy), 64'd0);
    s_req = 2'b01; s_inc = 16'h0001;
    tick();
    check("s_ovf_gnt", 64'(s_gnt), 64'h1);
    s_req = '0;
    tick();
    check("s_ovf_mid", 64'(s_counter), 64'hFF00);
    tick();
    check("s_ovf_counter", 64'(s_counter), 64'd0);
    check("s_ovf_set", 64'(s_ovf), 64'd1);
    s_req = 2'b01; s_inc = 16'h0003;
    tick();
    s_req = '0;
    tick();
    tick();
    check("s_sticky_counter", 64'(s_counter), 64'd3);
    check("s_sticky_ovf", 64'(s_ovf), 64'd1);
    s_clr = 1'b1;
    tick();
    s_clr = 1'b0;
    check("s_clr_ovf", 64'(s_ovf), 64'd0);
    check("s_clr_counter", 64'(s_counter), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/cnt_share_sched.md
Name: cnt_share_sched

Overview:
- Scheduler that shares one 64-bit accumulate counter between NUM_REQ requesters.
- Each requester posts a 32-bit increment. A round-robin arbiter picks one requester per update.
- The update runs as two sequenced 32-bit half-adds (low half, then carry into the high half), so only one 32-bit adder is needed.
- Sits between requester logic and the counter/readout path; `out` exposes the low 32 bits like the existing counter-readout blocks.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- INC_W, 32, increment width. Fixed equal to half of CNT_W.
- CNT_W, 64, accumulator width. Must equal 2*INC_W.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- clr  input  1  synchronous clear of counter, overflow flag and pointer. Highest priority.
- req  input  NUM_REQ  per-requester update request. Level; held until gnt.
- inc  input  NUM_REQ*INC_W  packed increments; slice i belongs to req[i]. Held stable while req[i]=1.
- gnt  output  NUM_REQ  one-hot grant, one-cycle pulse.
- counter  output  CNT_W  accumulator value.
- out  output  32  counter[31:0].
- busy  output  1  high while an update is in flight (state != IDLE).
- ovf  output  1  sticky; set on carry out of counter[63].

Behaviour:
- Reset (rst_n=0, async):
  - state=IDLE, counter=0, gnt=0, ovf=0, ptr=0, busy=0.
  - Internal inc_lat=0, win=0, carry=0.
- States: IDLE -> ADD_LO -> ADD_HI -> IDLE. Every update takes exactly 3 cycles, so peak throughput is 1 update per 3 cycles.
- IDLE, when any req=1 and clr=0:
  - win = first index i with req[i]=1, searching ptr, ptr+1, ... mod NUM_REQ.
  - inc_lat = inc slice of win.
  - Go to ADD_LO.
- IDLE, when no req: stay in IDLE.
- ADD_LO:
  - gnt[win]=1 for this cycle only; the requester sees the grant and may drop req or change inc next cycle.
  - {carry, counter[31:0]} <= counter[31:0] + inc_lat (33-bit result).
  - Go to ADD_HI.
- ADD_HI:
  - {c_hi, counter[63:32]} <= counter[63:32] + carry.
  - If c_hi=1, ovf<=1 and the counter wraps modulo 2^64.
  - ptr <= (win+1) mod NUM_REQ.
  - Go to IDLE.
- gnt is a registered decode of (state==ADD_LO, win); it is 0 in all other states.
- Requests arriving during ADD_LO/ADD_HI wait. No request is dropped while req stays high.
- A requester may withdraw req in IDLE before it is granted. There is no grant if req is low in the arbitration cycle.
- Fairness: with all req high, grants rotate 0,1,2,3,0,... Worst-case wait is NUM_REQ*3 cycles.
- clr=1, in any state:
  - Next state IDLE; counter=0, ovf=0, ptr=0.
  - Any in-flight update is discarded.
  - If clr arrives in ADD_LO, gnt still pulses that cycle (the request is consumed) but no add occurs.
  - clr in IDLE with req pending: no grant that cycle.
- counter/out are valid and coherent only when busy=0. Between ADD_LO and ADD_HI the low half is already updated but the carry has not yet reached the high half.
- Reset asserted mid-update: state and counter return to reset values immediately; gnt deasserts asynchronously.
- Width rules:
  - inc is zero-extended to 33 bits for the low add.
  - Carry is 1 bit.
  - No saturation; the counter always wraps.

Test Plan:
- Reset then single request: rst_n low 2 cycles; req=4'b0001, inc[31:0]=5 -> gnt=4'b0001 one cycle after req; counter=5 and busy=0 on the 3rd cycle; out=5.
- Carry propagation: counter preloaded via updates to 32'hFFFF_FFFF; req0 with inc=1 -> after ADD_LO out=0 and counter[63:32]=0; after ADD_HI counter=64'h1_0000_0000.
- Round robin: req=4'b1111, all inc=1, held 12 cycles -> gnt sequence 0001,0010,0100,1000 spaced 3 cycles apart; counter=4.
- Overflow: drive counter to 64'hFFFF_FFFF_FFFF_FFFF; add 1 -> counter=0 and ovf=1. ovf stays 1 through further updates until clr.
- clr mid-operation: clr=1 in the ADD_LO cycle of an inc=7 update -> gnt pulses; next cycle state=IDLE, counter=0, ovf=0; the next grant goes to req0 (ptr=0).
- Async reset mid-update: drop rst_n during ADD_HI -> counter=0, gnt=0 and busy=0 without waiting for a clk edge.
